spi_txn_arbiter: RTL
====================

// Module: spi_txn_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one byte-wide SPI transmit engine between N_REQ requesters.
//  Grants the engine to one requester per transaction and drives that device's chip select.
//  Feeds bytes to the engine and holds the grant until the requester's last byte completes.
//  Sits between client logic and the SPI master; applies a timeout guard on the engine's done pulse.
// PARAMETERS
//  N_REQ    4     number of requesters / chip selects (2..8)
//  CS_GAP   2     idle cycles with all cs_n_o high between transactions (>=1)
//  TIMEOUT  1023  max cycles in WAIT for eng_done_i before abort (>=1)
// PORTS
//  clk_i        in   1        clock, all logic on posedge
//  arst_i       in   1        asynchronous reset, active-high
//  req_i        in   N_REQ    requester k has a byte ready on data_i[k]
//  data_i       in   8*N_REQ  byte of requester k at [8k+7:8k]
//  last_i       in   N_REQ    byte of requester k is the final byte of its transaction
//  ack_o        out  N_REQ    1-cycle pulse: byte of requester k accepted; next byte may be presented
//  done_o       out  N_REQ    1-cycle pulse: transaction of requester k completed normally
//  err_o        out  1        1-cycle pulse: transaction aborted on timeout
//  cs_n_o       out  N_REQ    per-device chip select, active-low, at most one low
//  eng_start_o  out  1        1-cycle pulse: engine loads eng_data_o and shifts it
//  eng_data_o   out  8        byte to engine, valid when eng_start_o=1
//  eng_done_i   in   1        1-cycle pulse from engine: byte shifted out
//  busy_o       out  1        high whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, owner=0, rr_ptr=0, cs_n_o all 1; ack_o, done_o, err_o, eng_start_o,
//   eng_data_o, busy_o all 0. Reset mid-transaction drops cs_n_o immediately; no done_o/err_o.
//  FSM: IDLE -> SETUP -> LOAD <-> WAIT -> RELEASE -> GAP -> IDLE.
//  IDLE: if |req_i, owner <= first k with req_i[k]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ; -> SETUP.
//  SETUP (1 cycle): cs_n_o[owner]=0 (registered, low from this cycle to end of WAIT); -> LOAD.
//  LOAD: if req_i[owner]: eng_start_o=1, eng_data_o=data_i[owner], ack_o[owner]=1 (same cycle,
//   decoded from state), last_q <= last_i[owner], -> WAIT. Otherwise stay; bus stays held.
//  WAIT: on eng_done_i: last_q=1 -> RELEASE with done pending; else -> LOAD (next byte).
//   tmo_cnt clears on WAIT entry, increments each WAIT cycle; tmo_cnt==TIMEOUT-1 with no eng_done_i
//   -> RELEASE with err pending. eng_done_i and timeout in the same cycle: done wins.
//  RELEASE (1 cycle): cs_n_o all 1; done_o[owner]=1 or err_o=1 (exactly one); rr_ptr <= owner+1 mod N_REQ.
//  GAP: CS_GAP-1 further cycles with cs_n_o all 1 (CS_GAP total incl. RELEASE); -> IDLE.
//  Latency: req_i in IDLE at cycle 0 -> cs_n low cycle 1 -> eng_start_o/ack_o cycle 2.
//  Min byte-to-byte spacing: eng_done_i cycle t -> next eng_start_o cycle t+1 if req_i held.
//  eng_done_i outside WAIT: ignored. req_i of non-owners: ignored until IDLE (no preemption).
//  data_i/last_i of owner sampled only when ack_o is issued.
//  tmo_cnt width $clog2(TIMEOUT+1); rr_ptr/owner width $clog2(N_REQ), wraps N_REQ-1 -> 0.
// TESTING
//  1. Single req_i[2], data 8'hA5, last=1; engine done 9 cycles after start -> cs_n_o=4'b1011 cycles 1..,
//     eng_start_o cycle 2 with 8'hA5, done_o[2] pulse, cs_n_o all high >= CS_GAP cycles.
//  2. req_i=4'b1111 held, each single-byte -> grants 0,1,2,3,0 in order; one cs_n low at a time.
//  3. Requester 1 sends 3 bytes 11,22,33 (last on 33) -> 3 ack_o[1] pulses, cs_n_o[1] low throughout,
//     single done_o[1]; requester 0 requesting meanwhile granted only afterwards.
//  4. Engine never returns done -> err_o pulse after TIMEOUT WAIT cycles, no done_o, rr_ptr advances.
//  5. eng_done_i on same cycle as timeout expiry -> done_o, no err_o; stray eng_done_i in IDLE -> no effect.
//  6. arst_i asserted in WAIT -> cs_n_o all 1 asynchronously, outputs 0; after release, fresh grant from
//     requester 0.

Source files
------------

// File: rtl/spi_txn_arbiter_if.sv
// Client and engine side signals of the SPI transaction arbiter.
// The master modport is the arbiter's view; slave is the view of the client
// logic and SPI engine that surround it.
interface spi_txn_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_i;
   logic [8*N_REQ-1:0] data_i;
   logic [N_REQ-1:0]   last_i;
   logic [N_REQ-1:0]   ack_o;
   logic [N_REQ-1:0]   done_o;
   logic               err_o;
   logic [N_REQ-1:0]   cs_n_o;
   logic               eng_start_o;
   logic [7:0]         eng_data_o;
   logic               eng_done_i;
   logic               busy_o;

   modport master (
      input  req_i, data_i, last_i, eng_done_i,
      output ack_o, done_o, err_o, cs_n_o, eng_start_o, eng_data_o, busy_o
   );

   modport slave (
      output req_i, data_i, last_i, eng_done_i,
      input  ack_o, done_o, err_o, cs_n_o, eng_start_o, eng_data_o, busy_o
   );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin sequencer sharing one byte-wide SPI transmit engine between
// N_REQ requesters. One requester owns the engine and its chip select for a
// whole multi-byte transaction; a done-pulse timeout aborts a stuck engine.
module spi_txn_arbiter #(
   parameter int N_REQ   = 4,
   parameter int CS_GAP  = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk_i,
   input  logic              arst_i,
   spi_txn_arbiter_if.master bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_LOAD, S_WAIT, S_RELEASE, S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    owner_q, rr_ptr_q, pick;
   logic             last_q, err_q;
   logic [TW-1:0]    tmo_q;
   logic [GW-1:0]    gap_q;
   logic [N_REQ-1:0] cs_n_q;

   logic [N_REQ-1:0] ack_c, done_c;
   logic             err_c, start_c;
   logic [7:0]       data_c;

   logic             own_req, own_last, tmo_hit, gap_end;
   logic [7:0]       own_data;

   assign own_req  = bus.req_i[owner_q];
   assign own_last = bus.last_i[owner_q];
   assign own_data = bus.data_i[{owner_q, 3'b000} +: 8];
   assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
   assign gap_end  = (gap_q == GW'(CS_GAP - 2));

   // Round-robin pick: first requester at or after rr_ptr (descending loop so the nearest wins).
   always_comb begin
      int idx;
      idx  = 0;
      pick = rr_ptr_q;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr_q) + i) % N_REQ;
         if (bus.req_i[idx]) pick = PW'(idx);
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and the single-cycle pulses decoded from the current state.
   always_comb begin
      state_d = state_q;
      ack_c   = '0;
      done_c  = '0;
      err_c   = 1'b0;
      start_c = 1'b0;
      data_c  = 8'h00;
      case (state_q)
         S_IDLE:  if (|bus.req_i) state_d = S_SETUP;
         S_SETUP: state_d = S_LOAD;
         S_LOAD: begin
            if (own_req) begin
               start_c        = 1'b1;
               data_c         = own_data;
               ack_c[owner_q] = 1'b1;
               state_d        = S_WAIT;
            end
         end
         S_WAIT: begin
            // A done pulse coinciding with the timeout still counts as done.
            if (bus.eng_done_i) state_d = last_q ? S_RELEASE : S_LOAD;
            else if (tmo_hit)   state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (err_q) err_c           = 1'b1;
            else       done_c[owner_q] = 1'b1;
            state_d = (CS_GAP > 1) ? S_GAP : S_IDLE;
         end
         S_GAP:   if (gap_end) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Owner, round-robin pointer, chip select, timeout and gap counters.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         owner_q  <= '0;
         rr_ptr_q <= '0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
         tmo_q    <= '0;
         gap_q    <= '0;
         cs_n_q   <= '1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|bus.req_i) begin
                  owner_q <= pick;
                  cs_n_q  <= ~(ONE << pick);
               end
            end
            S_LOAD: begin
               if (own_req) begin
                  last_q <= own_last;
                  tmo_q  <= '0;
               end
            end
            S_WAIT: begin
               tmo_q <= tmo_q + TW'(1);
               if (bus.eng_done_i ? last_q : tmo_hit) begin
                  cs_n_q <= '1;
                  err_q  <= ~bus.eng_done_i;
               end
            end
            S_RELEASE: begin
               rr_ptr_q <= (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
               gap_q    <= '0;
            end
            S_GAP:   gap_q <= gap_q + GW'(1);
            default: ;
         endcase
      end
   end

   assign bus.ack_o       = ack_c;
   assign bus.done_o      = done_c;
   assign bus.err_o       = err_c;
   assign bus.cs_n_o      = cs_n_q;
   assign bus.eng_start_o = start_c;
   assign bus.eng_data_o  = data_c;
   assign bus.busy_o      = (state_q != S_IDLE);
endmodule
